led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//  Row-multiplexing driver for the 8x8 bicolour LED matrix. Consumes the
//  redarray/greenarray frame produced by the LED mapping stage. Latches it as a
//  tear-free snapshot once per frame and scans one row at a time. Drives the
//  physical row-enable and active-low colour column pins.
// PARAMETERS
//  DWELL_CYC  2500  clk cycles a row is lit per visit (>=1)
//  BLANK_CYC  50    clk cycles all pins are off before each row (anti-ghost; 0 = none)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high
//  enable       in   1      scan enable; low = display dark
//  redarray     in   8x8    [row][col] red frame, 1 = lit
//  greenarray   in   8x8    [row][col] green frame, 1 = lit
//  row_sel      out  8      one-hot row enable, active-high
//  red_col_n    out  8      red column drive, active-low
//  green_col_n  out  8      green column drive, active-low
//  row_idx      out  3      row currently owned by the scan
//  frame_start  out  1      one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, row_idx=0, row_sel=8'h00,
//    red_col_n=green_col_n=8'hFF, frame_start=0, counter=0, snapshots cleared.
//  - All outputs are registered and change on the same edge as the state.
//  - States:
//    IDLE -> BLANK when enable=1. On that edge: snapshot both arrays,
//    frame_start=1, row_idx=0.
//    BLANK: row_sel=0, cols=FF. Hold BLANK_CYC cycles, then go to DRIVE.
//    If BLANK_CYC=0, IDLE/row-advance goes straight to DRIVE.
//    DRIVE: row_sel=1<<row_idx, red_col_n=~red_snap[row_idx],
//    green_col_n=~green_snap[row_idx]. Hold DWELL_CYC cycles.
//    Then row_idx+1 and go to BLANK or DRIVE.
//  - Wrap: leaving DRIVE with row_idx=7 sets row_idx=0 and re-snapshots both
//    arrays. frame_start=1 for exactly that one cycle.
//  - Frame period = 8*(BLANK_CYC+DWELL_CYC) cycles.
//  - Input changes mid-frame are ignored until the next wrap. No partial frames.
//  - enable=0 in any state: next edge -> IDLE, row_idx=0, row_sel=0, cols=FF.
//    Snapshot is retained but unused.
//  - Reset mid-scan has the same effect as the reset values above, on the next
//    edge. Reset has priority over enable.
//  - Counter width: $clog2(max(DWELL_CYC,BLANK_CYC)+1). Counter clears on every
//    state change. Never more than one row_sel bit set. Rows never overlap.
//  - Column bit mapping: col_n[c] corresponds to array[row][c]. No reordering.
// STRUCTURE
//  - Package led_pkg: MATRIX_ROWS=8, MATRIX_COLS=8, typedef
//    logic [7:0][7:0] led_frame_t, and enum scan_state_t {IDLE,BLANK,DRIVE}.
//  - One sub-module, scan_timer: loadable down-counter with terminal-count
//    output, instantiated once. The FSM, row counter and snapshot registers
//    live in the top module.
// TESTING (DWELL_CYC=4, BLANK_CYC=1)
//  1. Reset held 3 cycles, enable=1 -> row_sel=00, cols=FF, frame_start=0
//     throughout.
//  2. Release reset, enable=1, red[0]=8'hA5 -> frame_start pulses 1 cycle;
//     1 cycle blank; then row_sel=01, red_col_n=5A for 4 cycles.
//  3. Full scan -> row_sel steps 01,02,..,80, each lit 4 of 5 cycles.
//     frame_start repeats every 40 cycles. Never two row bits set.
//  4. Change greenarray[3] from 00 to FF at cycle 12 of a frame -> row 3 still
//     shows green_col_n=FF in that frame and 00 in the next frame.
//  5. Drop enable during row 5 DRIVE -> next edge row_sel=00, cols=FF,
//     row_idx=0. Re-enable -> new frame_start, scan restarts at row 0.
//  6. Assert reset during row 2 DRIVE -> next edge all reset values.
//     BLANK_CYC=0 build -> rows back-to-back, period 32 cycles.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared types and constants for the 8x8 bicolour LED matrix
//             scanner: frame type, scan state encoding and a row decoder.
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    // [row][col], bit = 1 means the LED is lit
    typedef logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0] led_frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // One-hot row enable for a row index
    function automatic logic [MATRIX_ROWS-1:0] row_onehot(input logic [2:0] idx);
        logic [MATRIX_ROWS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Loadable down-counter. Stops at zero; o_tc is high while the
//             count is zero. A load of N-1 therefore gives an N-cycle interval.
//  Ports    : clk        system clock
//             rst        synchronous active-high reset (count -> 0)
//             i_clr      synchronous clear (count -> 0)
//             i_load     load i_load_val on the next edge
//             i_load_val value to load
//             o_tc       terminal count (count == 0)
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scanner
//  Purpose  : Row-multiplexing driver for the 8x8 bicolour LED matrix. Takes a
//             tear-free snapshot of the red/green frame once per frame and
//             scans one row at a time, with an optional all-off blanking gap
//             before each row to suppress ghosting.
//  Ports    : clk          system clock
//             reset        synchronous, active-high
//             enable       scan enable; low = display dark
//             redarray     [row][col] red frame, 1 = lit
//             greenarray   [row][col] green frame, 1 = lit
//             row_sel      one-hot row enable, active-high
//             red_col_n    red column drive, active-low
//             green_col_n  green column drive, active-low
//             row_idx      row currently owned by the scan
//             frame_start  one-cycle pulse when a new snapshot is taken
//  Revision : 1.0  initial release
// ============================================================================
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int DWELL_CYC = 2500,
    parameter int BLANK_CYC = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  led_frame_t redarray,
    input  led_frame_t greenarray,
    output logic [7:0] row_sel,
    output logic [7:0] red_col_n,
    output logic [7:0] green_col_n,
    output logic [2:0] row_idx,
    output logic       frame_start
);

    localparam int c_max_cyc = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam bit               c_has_blank = (BLANK_CYC > 0);
    localparam logic [c_cnt_w-1:0] c_dwell_ld  = c_cnt_w'(DWELL_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_blank_ld  = c_cnt_w'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    // Interval that follows IDLE or the end of a row: blanking if present
    localparam logic [c_cnt_w-1:0] c_next_ld   = c_has_blank ? c_blank_ld : c_dwell_ld;
    localparam logic [2:0]         c_last_row  = 3'(MATRIX_ROWS - 1);

    scan_state_t  r_state;
    logic [2:0]   r_row_idx;
    logic [7:0]   r_row_sel;
    logic [7:0]   r_red_col_n;
    logic [7:0]   r_green_col_n;
    logic         r_frame_start;
    led_frame_t   r_red_snap;
    led_frame_t   r_green_snap;

    logic               w_tc;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_val;
    logic [2:0]         w_next_row;
    logic               w_wrap;
    logic [7:0]         w_next_red;
    logic [7:0]         w_next_green;

    assign w_next_row = r_row_idx + 3'd1;
    assign w_wrap     = (r_row_idx == c_last_row);

    // Without blanking, the row after a wrap is lit on the same edge the new
    // snapshot is taken, so its columns must come straight from the inputs.
    assign w_next_red   = w_wrap ? redarray[0]   : r_red_snap[w_next_row];
    assign w_next_green = w_wrap ? greenarray[0] : r_green_snap[w_next_row];

    // Timer is reloaded on every state transition (including DRIVE->DRIVE
    // row advances), so each state sees a fresh interval from its first cycle.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_dwell_ld;
        case (r_state)
            IDLE: begin
                w_load     = 1'b1;
                w_load_val = c_next_ld;
            end
            BLANK: begin
                w_load     = w_tc;
                w_load_val = c_dwell_ld;
            end
            DRIVE: begin
                w_load     = w_tc;
                w_load_val = c_next_ld;
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = c_dwell_ld;
            end
        endcase
    end

    scan_timer #(
        .WIDTH (c_cnt_w)
    ) u_scan_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clr      (~enable),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_row_idx     <= '0;
            r_row_sel     <= '0;
            r_red_col_n   <= '1;
            r_green_col_n <= '1;
            r_frame_start <= 1'b0;
            r_red_snap    <= '0;
            r_green_snap  <= '0;
        end else if (!enable) begin
            // Snapshots are deliberately kept; they are refreshed on re-enable
            r_state       <= IDLE;
            r_row_idx     <= '0;
            r_row_sel     <= '0;
            r_red_col_n   <= '1;
            r_green_col_n <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_red_snap    <= redarray;
                    r_green_snap  <= greenarray;
                    r_frame_start <= 1'b1;
                    r_row_idx     <= '0;
                    if (c_has_blank) begin
                        r_state       <= BLANK;
                        r_row_sel     <= '0;
                        r_red_col_n   <= '1;
                        r_green_col_n <= '1;
                    end else begin
                        r_state       <= DRIVE;
                        r_row_sel     <= row_onehot(3'd0);
                        r_red_col_n   <= ~redarray[0];
                        r_green_col_n <= ~greenarray[0];
                    end
                end
                BLANK: begin
                    if (w_tc) begin
                        r_state       <= DRIVE;
                        r_row_sel     <= row_onehot(r_row_idx);
                        r_red_col_n   <= ~r_red_snap[r_row_idx];
                        r_green_col_n <= ~r_green_snap[r_row_idx];
                    end
                end
                DRIVE: begin
                    if (w_tc) begin
                        r_row_idx <= w_next_row;
                        if (w_wrap) begin
                            r_red_snap    <= redarray;
                            r_green_snap  <= greenarray;
                            r_frame_start <= 1'b1;
                        end
                        if (c_has_blank) begin
                            r_state       <= BLANK;
                            r_row_sel     <= '0;
                            r_red_col_n   <= '1;
                            r_green_col_n <= '1;
                        end else begin
                            r_state       <= DRIVE;
                            r_row_sel     <= row_onehot(w_next_row);
                            r_red_col_n   <= ~w_next_red;
                            r_green_col_n <= ~w_next_green;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_row_idx     <= '0;
                    r_row_sel     <= '0;
                    r_red_col_n   <= '1;
                    r_green_col_n <= '1;
                end
            endcase
        end
    end

    assign row_sel     = r_row_sel;
    assign red_col_n   = r_red_col_n;
    assign green_col_n = r_green_col_n;
    assign row_idx     = r_row_idx;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scanner
//  Purpose  : Directed self-checking bench for led_matrix_scanner with
//             DWELL_CYC=4/BLANK_CYC=1, plus a BLANK_CYC=0 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_matrix_scanner;
    import led_pkg::*;

    localparam logic [7:0] RED_TAB   [8] = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hF0, 8'h0F, 8'h55, 8'hC3};
    localparam logic [7:0] EXP_RED_N [8] = '{8'h5A, 8'hC3, 8'hFE, 8'h7F, 8'h0F, 8'hF0, 8'hAA, 8'h3C};

    logic       clk;
    logic       reset;
    logic       enable;
    led_frame_t red_in;
    led_frame_t green_in;

    logic [7:0] row_sel, red_col_n, green_col_n;
    logic [2:0] row_idx;
    logic       frame_start;

    logic [7:0] nb_row_sel, nb_red_col_n, nb_green_col_n;
    logic [2:0] nb_row_idx;
    logic       nb_frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    led_matrix_scanner #(.DWELL_CYC(4), .BLANK_CYC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .redarray    (red_in),
        .greenarray  (green_in),
        .row_sel     (row_sel),
        .red_col_n   (red_col_n),
        .green_col_n (green_col_n),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    led_matrix_scanner #(.DWELL_CYC(4), .BLANK_CYC(0)) dut_nb (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .redarray    (red_in),
        .greenarray  (green_in),
        .row_sel     (nb_row_sel),
        .red_col_n   (nb_red_col_n),
        .green_col_n (nb_green_col_n),
        .row_idx     (nb_row_idx),
        .frame_start (nb_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p, row, ph, q, nrow;
        logic [7:0] exp_sel, exp_red, exp_grn, nb_sel;

        reset    = 1'b1;
        enable   = 1'b1;
        green_in = '0;
        for (int r = 0; r < 8; r++) red_in[r] = RED_TAB[r];

        // Reset held with enable high: display stays dark
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_row_sel", row_sel, 8'h00);
            check("rst_cols", {red_col_n, green_col_n}, 16'hFFFF);
            check("rst_frame_start", frame_start, 1'b0);
            check("rst_row_idx", row_idx, 3'd0);
        end

        // Two full frames and most of a third; green row 3 changes mid-frame 0
        reset = 1'b0;
        for (int t = 0; t <= 106; t++) begin
            step();
            p   = t % 40;
            row = p / 5;
            ph  = p % 5;
            exp_sel = (ph == 0) ? 8'h00 : (8'h01 << row);
            exp_red = (ph == 0) ? 8'hFF : EXP_RED_N[row];
            exp_grn = (ph != 0 && row == 3) ? ((t < 40) ? 8'hFF : 8'h00) : 8'hFF;
            check("row_sel", row_sel, exp_sel);
            check("frame_start", frame_start, (p == 0));
            check("row_idx", row_idx, row[2:0]);
            check("cols", {red_col_n, green_col_n}, {exp_red, exp_grn});
            check("onehot", ($countones(row_sel) <= 1), 1'b1);

            q      = t % 32;
            nrow   = q / 4;
            nb_sel = 8'h01 << nrow;
            check("nb_row_sel", nb_row_sel, nb_sel);
            check("nb_frame_start", nb_frame_start, (q == 0));
            check("nb_red", nb_red_col_n, EXP_RED_N[nrow]);
            if (nrow == 3) check("nb_green", nb_green_col_n, (t < 32) ? 8'hFF : 8'h00);

            if (t == 12) green_in[3] = 8'hFF;
        end

        // Now in row 5 DRIVE: drop enable
        check("row5_drive", row_sel, 8'h20);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("dis_row_sel", row_sel, 8'h00);
            check("dis_cols", {red_col_n, green_col_n}, 16'hFFFF);
            check("dis_row_idx", row_idx, 3'd0);
            check("dis_frame_start", frame_start, 1'b0);
            check("nb_dis_row_sel", nb_row_sel, 8'h00);
        end

        // Re-enable: new frame from row 0
        enable = 1'b1;
        step();
        check("reen_frame_start", frame_start, 1'b1);
        check("reen_row_sel", row_sel, 8'h00);
        check("reen_row_idx", row_idx, 3'd0);
        check("nb_reen_frame_start", nb_frame_start, 1'b1);
        check("nb_reen_row_sel", nb_row_sel, 8'h01);
        step();
        check("reen_row0", row_sel, 8'h01);
        check("reen_red0", red_col_n, 8'h5A);
        check("reen_fs_low", frame_start, 1'b0);

        // Advance to row 2 DRIVE, then reset mid-scan
        for (int i = 0; i < 10; i++) step();
        check("row2_drive", row_sel, 8'h04);
        check("row2_red", red_col_n, 8'hFE);
        reset = 1'b1;
        step();
        check("mid_rst_row_sel", row_sel, 8'h00);
        check("mid_rst_cols", {red_col_n, green_col_n}, 16'hFFFF);
        check("mid_rst_row_idx", row_idx, 3'd0);
        check("mid_rst_frame_start", frame_start, 1'b0);
        check("nb_mid_rst_row_sel", nb_row_sel, 8'h00);
        check("nb_mid_rst_cols", {nb_red_col_n, nb_green_col_n}, 16'hFFFF);

        reset = 1'b0;
        step();
        check("post_rst_frame_start", frame_start, 1'b1);
        check("post_rst_row_sel", row_sel, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
